// File: rtl/hex_scroll_ctrl_if.sv
// Write port for the scroll message buffer: a requester holds wr_req with
// address/data until it sees the one-cycle wr_ack pulse.
interface hex_scroll_ctrl_if;
    logic       wr_req;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scrolling hex-message controller for six seven-segment displays.
// A small nibble buffer is filled over a req/ack port; a 6-digit window
// moves across the active length either continuously (prescaled tick)
// or one manual step at a time. All display outputs are registered.
module hex_scroll_ctrl #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned MSG_LEN  = 16
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    hex_scroll_ctrl_if.slave   wr,
    input  logic [4:0]         len,
    input  logic               run,
    input  logic               step,
    input  logic               dir,
    output logic [3:0]         pos,
    output logic [6:0]         HEX5,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX0
);

    localparam int unsigned     CW    = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   TC    = CW'(TICK_DIV - 1);
    localparam logic [4:0]      L_MAX = 5'(MSG_LEN);

    typedef enum logic [1:0] {HOLD, RUN, STEP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            step_q;
    logic            armed;
    logic [3:0]      msg_buf [MSG_LEN];

    logic [4:0]      len_c;
    logic [4:0]      pos_ext;
    logic            pos_oob;
    logic            step_edge;
    logic            adv;
    logic [3:0]      pos_adv;
    logic [4:0]      idx [6];
    logic [3:0]      dig [6];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Clamp requested length to the legal window range and derive the next position.
    always_comb begin
        len_c = len;
        if (len < 5'd6)
            len_c = 5'd6;
        else if (len > L_MAX)
            len_c = L_MAX;

        pos_ext   = {1'b0, pos};
        pos_oob   = (pos_ext >= len_c);
        step_edge = step & ~step_q;
        adv       = (state == STEP) || ((state == RUN) && run && (cnt == TC));

        if (dir)
            pos_adv = (pos == 4'd0) ? 4'(len_c - 5'd1) : pos - 4'd1;
        else
            pos_adv = ((pos_ext + 5'd1) == len_c) ? 4'd0 : pos + 4'd1;
    end

    // Window-to-buffer index mapping; out-of-buffer indices (only possible for
    // the single cycle before an out-of-range pos is cleared) read as zero.
    always_comb begin
        for (int unsigned k = 0; k < 6; k++) begin
            idx[k] = pos_ext + 5'(5 - k);
            if (idx[k] >= len_c)
                idx[k] = idx[k] - len_c;
            dig[k] = (idx[k] < L_MAX) ? msg_buf[idx[k][3:0]] : 4'd0;
        end
    end

    // Scroll FSM: tick prescaler, step edge detect and window position.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state  <= HOLD;
            cnt    <= '0;
            step_q <= 1'b0;
            pos    <= '0;
        end else begin
            step_q <= step;
            case (state)
                HOLD: begin
                    cnt <= '0;
                    if (run)
                        state <= RUN;
                    else if (step_edge)
                        state <= STEP;
                end
                RUN: begin
                    if (!run) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else if (cnt == TC) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STEP:    state <= HOLD;
                default: state <= HOLD;
            endcase

            // A shrunken length pulls pos back to 0 ahead of any advance.
            if (pos_oob)
                pos <= '0;
            else if (adv)
                pos <= pos_adv;
        end
    end

    // Write port: one buffer write and one ack pulse per wr_req assertion.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            armed     <= 1'b1;
            wr.wr_ack <= 1'b0;
            msg_buf   <= '{default: '0};
        end else begin
            wr.wr_ack <= 1'b0;
            if (wr.wr_req && armed) begin
                armed     <= 1'b0;
                wr.wr_ack <= 1'b1;
                if ({1'b0, wr.wr_addr} < L_MAX)
                    msg_buf[wr.wr_addr] <= wr.wr_data;
            end else if (!wr.wr_req) begin
                armed <= 1'b1;
            end
        end
    end

    // Registered segment outputs, blank while in reset.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            HEX5 <= 7'h7F;
            HEX4 <= 7'h7F;
            HEX3 <= 7'h7F;
            HEX2 <= 7'h7F;
            HEX1 <= 7'h7F;
            HEX0 <= 7'h7F;
        end else begin
            HEX5 <= seg7(dig[5]);
            HEX4 <= seg7(dig[4]);
            HEX3 <= seg7(dig[3]);
            HEX2 <= seg7(dig[2]);
            HEX1 <= seg7(dig[1]);
            HEX0 <= seg7(dig[0]);
        end
    end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with TICK_DIV=4, MSG_LEN=12.
module tb_hex_scroll_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic [4:0] len;
    logic       run, step, dir;
    logic [3:0] pos;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    hex_scroll_ctrl_if wr();

    hex_scroll_ctrl #(.TICK_DIV(4), .MSG_LEN(12)) dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .wr       (wr),
        .len      (len),
        .run      (run),
        .step     (step),
        .dir      (dir),
        .pos      (pos),
        .HEX5     (HEX5),
        .HEX4     (HEX4),
        .HEX3     (HEX3),
        .HEX2     (HEX2),
        .HEX1     (HEX1),
        .HEX0     (HEX0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] mbuf [12];

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  data;
        int unsigned hk;
        logic [6:0]  exp;
    } vec_t;
    vec_t vt [18];

    logic [41:0] disp;
    assign disp = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [41:0] disp_model(input int unsigned p, input int unsigned l);
        logic [41:0] r;
        for (int unsigned k = 0; k < 6; k++)
            r[k*7 +: 7] = glyph[mbuf[(p + 5 - k) % l]];
        return r;
    endfunction

    function automatic logic [6:0] hex_sel(input int unsigned k);
        case (k)
            0: return HEX0;
            1: return HEX1;
            2: return HEX2;
            3: return HEX3;
            4: return HEX4;
            default: return HEX5;
        endcase
    endfunction

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        int acks = 0;
        wr.wr_req  = 1'b1;
        wr.wr_addr = a;
        wr.wr_data = d;
        repeat (3) begin
            tick();
            if (wr.wr_ack) acks++;
        end
        wr.wr_req = 1'b0;
        tick();
        if (a < 4'd12) mbuf[a] = d;
        chk("ack_count", acks, 1);
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        int unsigned exp_pos, prev_pos;

        vt = '{
            '{4'd0,  4'h0, 5, 7'h40}, '{4'd1,  4'h1, 4, 7'h79}, '{4'd2,  4'h2, 3, 7'h24},
            '{4'd3,  4'h3, 2, 7'h30}, '{4'd4,  4'h4, 1, 7'h19}, '{4'd5,  4'h5, 0, 7'h12},
            '{4'd6,  4'h6, 0, 7'h12}, '{4'd7,  4'h7, 0, 7'h12}, '{4'd8,  4'h8, 0, 7'h12},
            '{4'd9,  4'h9, 0, 7'h12}, '{4'd0,  4'hF, 5, 7'h0E}, '{4'd3,  4'hA, 2, 7'h08},
            '{4'd5,  4'h8, 0, 7'h00}, '{4'd15, 4'h7, 5, 7'h0E}, '{4'd1,  4'hC, 4, 7'h46},
            '{4'd2,  4'hD, 3, 7'h21}, '{4'd4,  4'hE, 1, 7'h06}, '{4'd11, 4'hB, 5, 7'h0E}
        };
        foreach (mbuf[i]) mbuf[i] = 4'd0;

        wr.wr_req  = 1'b0;
        wr.wr_addr = 4'd0;
        wr.wr_data = 4'd0;
        len  = 5'd8;
        run  = 1'b0;
        step = 1'b0;
        dir  = 1'b0;

        // Reset and first load after release
        repeat (2) tick();
        chk("rst_hex", disp, {6{7'h7F}});
        chk("rst_pos", pos, 0);
        chk("rst_ack", wr.wr_ack, 0);
        Resetn = 1'b1;
        chk("rel_hex_before_edge", disp, {6{7'h7F}});
        tick();
        chk("rel_hex_zero", disp, {6{7'h40}});

        // Table-driven writes; addr 15 is beyond the buffer and must not change anything
        for (int i = 0; i < 18; i++) begin
            do_write(vt[i].addr, vt[i].data);
            chk("wr_glyph", hex_sel(vt[i].hk), vt[i].exp);
            chk("wr_disp", disp, disp_model(0, 8));
        end

        // Continuous scroll, L=8, dir=0: first advance TICK_DIV+1 cycles after run
        run = 1'b1;
        prev_pos = 0;
        for (int c = 1; c <= 36; c++) begin
            tick();
            exp_pos = (c < 5) ? 0 : ((c - 5) / 4 + 1) % 8;
            chk("scroll_pos", pos, exp_pos);
            chk("scroll_disp", disp, disp_model(prev_pos, 8));
            prev_pos = exp_pos;
        end
        run = 1'b0;
        tick();
        chk("run_stop_pos", pos, 0);

        // Reverse single steps: edge to pos change is two cycles
        dir  = 1'b1;
        step = 1'b1;
        tick();
        chk("step_lat1", pos, 0);
        tick();
        chk("step_rev_wrap", pos, 7);
        step = 1'b0;
        repeat (3) tick();
        chk("step_no_repeat", pos, 7);
        step = 1'b1;
        tick();
        tick();
        chk("step_rev2", pos, 6);
        step = 1'b0;
        repeat (2) tick();

        // Step edge coincident with run rising: run wins, no extra advance
        step = 1'b1;
        run  = 1'b1;
        repeat (4) begin
            tick();
            chk("run_wins_hold", pos, 6);
        end
        tick();
        chk("run_wins_tick", pos, 5);
        run  = 1'b0;
        step = 1'b0;
        tick();
        chk("run_wins_stop", pos, 5);

        // Length shrink and clamp
        len = 5'd12;
        dir = 1'b0;
        repeat (4) do_step();
        chk("pos_nine", pos, 9);
        chk("disp_pos9_l12", disp, disp_model(9, 12));
        len = 5'd3;
        tick();
        chk("len_clamp_low_pos", pos, 0);
        tick();
        chk("disp_l6", disp, disp_model(0, 6));
        len = 5'd31;
        dir = 1'b1;
        do_step();
        chk("len_clamp_high_wrap", pos, 11);
        chk("disp_pos11_l12", disp, disp_model(11, 12));
        dir = 1'b0;
        do_step();
        chk("len_high_fwd_wrap", pos, 0);

        // Async reset mid-scroll with a pending ack
        len = 5'd8;
        run = 1'b1;
        repeat (2) tick();
        wr.wr_req  = 1'b1;
        wr.wr_addr = 4'd2;
        wr.wr_data = 4'd3;
        tick();
        chk("pre_rst_ack", wr.wr_ack, 1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_ack", wr.wr_ack, 0);
        chk("arst_hex", disp, {6{7'h7F}});
        chk("arst_pos", pos, 0);
        wr.wr_req = 1'b0;
        run = 1'b0;
        foreach (mbuf[i]) mbuf[i] = 4'd0;
        tick();
        chk("arst_hold_hex", disp, {6{7'h7F}});
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_ack", wr.wr_ack, 0);
        end
        chk("post_rst_pos", pos, 0);
        chk("post_rst_buf_clear", disp, {6{7'h40}});
        do_write(4'd2, 4'd3);
        chk("post_rst_write", disp, disp_model(0, 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Scrolling-message controller for the six DE-series seven-segment displays. Holds a buffer of up to MSG_LEN hex digits, written by a requester over a req/ack handshake, and sequences a 6-digit window across it. The window moves continuously at a prescaled rate or one step at a time. It sits between board-level inputs (SW, KEY, or a user datapath) and the HEX0–HEX5 pins in a top-level DE-series design.

## Interface
- TICK_DIV, 25_000_000, CLOCK_50 cycles per scroll step (0.5 s); legal ≥ 2.
- MSG_LEN, 16, buffer depth in nibbles; legal 6..16.

- CLOCK_50  in  1  sole clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- wr_req  in  1  write request; held until wr_ack.
- wr_addr  in  4  buffer index; writes with wr_addr ≥ MSG_LEN are acked and discarded.
- wr_data  in  4  hex nibble.
- wr_ack  out  1  one-cycle accept pulse.
- len  in  5  active message length L; clamped to 6 if below 6, to MSG_LEN if above.
- run  in  1  level; 1 = continuous scroll.
- step  in  1  level, active-high; each 0→1 edge = one manual advance.
- dir  in  1  0 = pos increments (text moves left), 1 = pos decrements.
- pos  out  4  current window start index.
- HEX5..HEX0  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX5 is leftmost.

## Operation
- Buffer buf[0..MSG_LEN-1] of 4-bit entries; all 0 on reset.
- Display: HEXk shows decode(buf[(pos + 5 − k) mod L]). HEX5 = buf[pos]; HEX0 = buf[(pos+5) mod L].
- Decoder: standard 0–F glyphs, active-low (0 = 7'h40, 8 = 7'h00, F = 7'h0E).
- FSM states:
  - HOLD: tick counter held at 0.
  - RUN: counter counts 0..TICK_DIV−1. At terminal count, advance pos and set counter to 0.
  - STEP: one cycle; advance pos, then return to HOLD.
- Transitions:
  - HOLD→RUN when run=1.
  - RUN→HOLD when run=0; counter clears.
  - HOLD→STEP on a step rising edge. The edge detector is a registered previous-step value.
- Step edges in RUN or STEP are ignored, not queued.
- If run=1 and a step edge occur in the same HOLD cycle, run wins.
- Advance:
  - dir=0: pos ← (pos+1 = L) ? 0 : pos+1.
  - dir=1: pos ← (pos = 0) ? L−1 : pos−1.
  - dir is sampled at the advance cycle.
- Length change: if pos ≥ clamped L in any cycle, pos ← 0 on the next edge. This takes priority over an advance in that cycle.
- Write handshake:
  - Sampled wr_req=1 with the armed flag set: buf written at that edge, wr_ack=1 the following cycle, armed cleared.
  - armed is set again only after wr_req is sampled 0. This gives exactly one write per request even if wr_req is held.
  - Writes are accepted in every FSM state. A write and a pos advance in the same cycle both take effect.

## Timing
- Reset (async assert, sync release): pos=0, state=HOLD, counter=0, armed=1, wr_ack=0, all HEX=7'h7F (blank).
- First edge after release: HEX registers load from the buffer, so all digits show "0" (7'h40).
- HEX outputs are registered: 1 cycle after any buf or pos change.
- pos is a direct register output.
- wr_req to wr_ack: 1 cycle. wr_ack to new glyph on HEX: 1 cycle.
- run rising edge to first advance: TICK_DIV+1 cycles (HOLD→RUN takes 1 cycle, then a full count).
- Step edge to pos change: 2 cycles (edge register, then STEP state).
- Resetn low mid-operation: all state returns immediately to the reset values, including a pending ack; buffer contents clear.

## Test plan
- Reset: Resetn low, then high → all HEX = 7'h7F, then 7'h40 one cycle after release; pos=0; wr_ack=0.
- Write handshake: write 0..9 to addr 0..9 with wr_req held 3 cycles each → exactly one wr_ack per request; HEX5..HEX0 show 0,1,2,3,4,5. Writing to addr 15 with MSG_LEN=12 → acked, no digit change.
- Continuous scroll: TICK_DIV=4, L=8, dir=0, run=1 → pos advances every 4 cycles, sequence 0,1,…,7,0; at pos=5, HEX5..HEX0 = buf5,6,7,0,1,2.
- Reverse and step: run=0, dir=1, pos=0; step edges separated by idle cycles → pos 7, then 6. A step edge in the same cycle as run rising → pos unchanged until the tick.
- Length shrink and clamp: pos=9 with L=12, then set len=3 → L clamps to 6 and pos=0 next cycle. len=31 → L=MSG_LEN.
- Async reset mid-scroll: assert Resetn during RUN with wr_req high → all outputs return to reset values within the same cycle, and no ack appears after release until wr_req is deasserted and reasserted.
